// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared state encodings, grant codes and timing defaults for the DDR request arbiter.
package ddr_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  localparam logic [1:0] GID_INS = 2'd0;
  localparam logic [1:0] GID_DRD = 2'd1;
  localparam logic [1:0] GID_STORE = 2'd2;
  localparam logic [1:0] GID_JMP = 2'd3;
  localparam int DEF_STARVE_LIMIT = 16;
  localparam int DEF_GAP_CYCLES = 2;
endpackage

// File: rtl/ddr_req_arbiter_if.sv
// ddr_req_arbiter_if: requester, completion and DDR burst-port signals of the arbiter.
interface ddr_req_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LEN_W = 8
);
  logic init_done;
  logic ic_rd_req, dc_rd_req, dc_wr_req, jmp_rd_req;
  logic [ADDR_W-1:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, jmp_rd_addr;
  logic [LEN_W-1:0] ic_rd_len;
  logic ic_done, dc_rd_done, dc_wr_done, jmp_done;
  logic ddr_ins_read_req, ddr_data_read_req, ddr_data_store_req, ddr_jmp_read_req;
  logic [ADDR_W-1:0] ddr_rd_addr, ddr_wr_addr;
  logic [LEN_W-1:0] ddr_ins_len;
  logic rd_burst_finish, wr_burst_finish;
  logic busy;
  logic [1:0] grant_id;
  modport slave (
    input init_done, ic_rd_req, dc_rd_req, dc_wr_req, jmp_rd_req,
    input ic_rd_addr, dc_rd_addr, dc_wr_addr, jmp_rd_addr, ic_rd_len,
    input rd_burst_finish, wr_burst_finish,
    output ic_done, dc_rd_done, dc_wr_done, jmp_done,
    output ddr_ins_read_req, ddr_data_read_req, ddr_data_store_req, ddr_jmp_read_req,
    output ddr_rd_addr, ddr_wr_addr, ddr_ins_len, busy, grant_id
  );
  modport master (
    output init_done, ic_rd_req, dc_rd_req, dc_wr_req, jmp_rd_req,
    output ic_rd_addr, dc_rd_addr, dc_wr_addr, jmp_rd_addr, ic_rd_len,
    output rd_burst_finish, wr_burst_finish,
    input ic_done, dc_rd_done, dc_wr_done, jmp_done,
    input ddr_ins_read_req, ddr_data_read_req, ddr_data_store_req, ddr_jmp_read_req,
    input ddr_rd_addr, ddr_wr_addr, ddr_ins_len, busy, grant_id
  );
endinterface

// File: rtl/ddr_arb_pick.sv
// ddr_arb_pick: fixed-priority pick (store > jump > data read > ins) with starved-ins override.
module ddr_arb_pick
  import ddr_arb_pkg::*;
(
  input  logic       ic,
  input  logic       drd,
  input  logic       wr,
  input  logic       jmp,
  input  logic       starve,
  output logic       valid,
  output logic [1:0] gid
);
  always_comb begin
    valid = ic | drd | wr | jmp;
    gid = (starve && ic) ? GID_INS : wr ? GID_STORE : jmp ? GID_JMP : drd ? GID_DRD : GID_INS;
  end
endmodule

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: grants the shared DDR burst port to one cache requester at a time.
module ddr_req_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int LEN_W = 8,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic mem_clk,
  input logic rst,
  ddr_req_arbiter_if.slave bus
);
  state_t state, state_nx;
  logic [7:0] scnt, gcnt;
  logic [3:0] req, done;
  logic [1:0] gid, pick_id;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [LEN_W-1:0] ins_len;
  logic pick_v, starve, grant, fin, ic_owner, gap_end;
  ddr_arb_pick u_pick (
    .ic(bus.ic_rd_req), .drd(bus.dc_rd_req), .wr(bus.dc_wr_req), .jmp(bus.jmp_rd_req),
    .starve(starve), .valid(pick_v), .gid(pick_id)
  );
  always_comb begin
    starve = scnt == 8'(STARVE_LIMIT);
    grant = state == IDLE && bus.init_done && pick_v;
    fin = state == ISSUE && (gid == GID_STORE ? bus.wr_burst_finish : bus.rd_burst_finish);
    ic_owner = state == ISSUE && gid == GID_INS;
    gap_end = gcnt == 8'(GAP_CYCLES - 1);
    state_nx = state == IDLE ? (grant ? ISSUE : IDLE) :
               state == ISSUE ? (fin ? GAP : ISSUE) : (gap_end ? IDLE : GAP);
  end
  always_ff @(posedge mem_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      scnt <= '0;
      gcnt <= '0;
      req <= '0;
      done <= '0;
      gid <= GID_INS;
      rd_addr <= '0;
      wr_addr <= '0;
      ins_len <= '0;
    end else begin
      state <= state_nx;
      scnt <= (!bus.ic_rd_req || (grant && pick_id == GID_INS)) ? '0 :
              (ic_owner || starve) ? scnt : scnt + 8'd1;
      gcnt <= state == GAP ? gcnt + 8'd1 : '0;
      done <= '0;
      if (grant) begin
        req <= 4'b1 << pick_id;
        gid <= pick_id;
        rd_addr <= pick_id == GID_INS ? bus.ic_rd_addr : pick_id == GID_DRD ? bus.dc_rd_addr :
                   pick_id == GID_JMP ? bus.jmp_rd_addr : '0;
        wr_addr <= pick_id == GID_STORE ? bus.dc_wr_addr : '0;
        ins_len <= pick_id == GID_INS ? bus.ic_rd_len : '0;
      end else if (fin) begin
        req <= '0;
        rd_addr <= '0;
        wr_addr <= '0;
        ins_len <= '0;
        done <= 4'b1 << gid;
      end
    end
  assign {bus.ddr_jmp_read_req, bus.ddr_data_store_req, bus.ddr_data_read_req, bus.ddr_ins_read_req} = req;
  assign {bus.jmp_done, bus.dc_wr_done, bus.dc_rd_done, bus.ic_done} = done;
  assign bus.ddr_rd_addr = rd_addr;
  assign bus.ddr_wr_addr = wr_addr;
  assign bus.ddr_ins_len = ins_len;
  assign bus.grant_id = gid;
  assign bus.busy = state != IDLE;
endmodule
